// File: rtl/pipe_pkg.sv
// Shared pipeline types: stall polarity, the EX/MEM payload layout and the
// multi-cycle HI/LO sidecar layout used by the inter-stage registers.
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } exmem_payload_t;

    typedef struct packed {
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } hilo_side_t;

    localparam int PAYLOAD_W = $bits(exmem_payload_t);
    localparam int SIDE_W    = $bits(hilo_side_t);

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; also used by the perf-counter block.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count up while inc is high, pinning at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid under the global stall
// vector and flush, registered multi-cycle sidecar, bubble flag and a
// saturating count of consecutive stalled cycles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W    = pipe_pkg::PAYLOAD_W,
    parameter int SIDE_W       = pipe_pkg::SIDE_W,
    parameter int STALL_W      = 6,
    parameter int STAGE        = 3,
    parameter int CNT_W        = 8,
    parameter bit GATE_INVALID = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [SIDE_W-1:0]    side_i,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [SIDE_W-1:0]    side_o,
    output logic                 bubble_o,
    output logic [CNT_W-1:0]     stall_cycles_o
);

    // The consumer stage index must exist in the stall vector.
    if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE must be in 0..STALL_W-2");
    end

    logic                 stall_here;
    logic                 stall_next;
    logic                 is_bubble;
    logic                 is_advance;
    logic [PAYLOAD_W-1:0] adv_payload;

    assign stall_here = (stall[STAGE]   == STOP);
    assign stall_next = (stall[STAGE+1] == STOP);
    assign is_bubble  = stall_here && !stall_next;
    // The illegal combination (this stage running, next stopped) falls into advance.
    assign is_advance = !stall_here;

    // Payload presented on an advancing edge, zeroed for invalid slots when gating.
    always_comb begin
        // NOTE: assign a default first so no path leaves the output unassigned
        // (which would infer a latch).
        adv_payload = in_payload;
        if (GATE_INVALID && !in_valid) begin
            adv_payload = '0;
        end
    end

    // Stage register: flush/rst clear, bubble inserts a NOP, advance loads, hold keeps.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            side_o      <= '0;
            bubble_o    <= 1'b0;
        end else if (is_bubble) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            side_o      <= side_i;
            bubble_o    <= 1'b1;
        end else if (is_advance) begin
            out_valid   <= in_valid;
            out_payload <= adv_payload;
            side_o      <= '0;
            bubble_o    <= 1'b0;
        end else begin
            side_o      <= side_i;
            bubble_o    <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_here),
        .clr   (flush || is_advance),
        .count (stall_cycles_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by
// random legal stall traffic, checked against a cycle-level reference model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int PW = pipe_pkg::PAYLOAD_W;
    localparam int SW = pipe_pkg::SIDE_W;
    localparam int STW = 6;
    localparam int STG = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [STW-1:0] stall;
    logic           flush;
    logic           in_valid;
    logic [PW-1:0]  in_payload;
    logic [SW-1:0]  side_i;

    logic           out_valid,   out_valid_c2;
    logic [PW-1:0]  out_payload, out_payload_c2;
    logic [SW-1:0]  side_o,      side_o_c2;
    logic           bubble_o,    bubble_o_c2;
    logic [7:0]     cnt8;
    logic [1:0]     cnt2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: what the consuming stage should see, plus the length
    // of the current run of stalled cycles (saturated only when compared).
    logic          m_valid;
    logic [PW-1:0] m_payload;
    logic [SW-1:0] m_side;
    logic          m_bubble;
    int            m_run;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .side_i(side_i),
        .out_valid(out_valid), .out_payload(out_payload), .side_o(side_o),
        .bubble_o(bubble_o), .stall_cycles_o(cnt8)
    );

    pipe_stage_reg #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .side_i(side_i),
        .out_valid(out_valid_c2), .out_payload(out_payload_c2), .side_o(side_o_c2),
        .bubble_o(bubble_o_c2), .stall_cycles_o(cnt2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next-state of the model from the inputs present at the coming edge.
    task automatic model_step();
        if (rst || flush) begin
            m_valid = 1'b0; m_payload = '0; m_side = '0; m_bubble = 1'b0; m_run = 0;
        end else if (!stall[STG]) begin
            m_valid   = in_valid;
            m_payload = in_valid ? in_payload : '0;
            m_side    = '0;
            m_bubble  = 1'b0;
            m_run     = 0;
        end else begin
            m_side   = side_i;
            m_bubble = !stall[STG+1];
            m_run    = m_run + 1;
            if (!stall[STG+1]) begin
                m_valid   = 1'b0;
                m_payload = '0;
            end
        end
    endtask

    // One clock: advance model, pass the edge, compare both instances.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("valid",    128'(out_valid),      128'(m_valid));
        check("payload",  128'(out_payload),    128'(m_payload));
        check("side",     128'(side_o),         128'(m_side));
        check("bubble",   128'(bubble_o),       128'(m_bubble));
        check("cnt8",     128'(cnt8),           128'((m_run > 255) ? 255 : m_run));
        check("valid_c2", 128'(out_valid_c2),   128'(m_valid));
        check("payld_c2", 128'(out_payload_c2), 128'(m_payload));
        check("side_c2",  128'(side_o_c2),      128'(m_side));
        check("bubl_c2",  128'(bubble_o_c2),    128'(m_bubble));
        check("cnt2",     128'(cnt2),           128'((m_run > 3) ? 3 : m_run));
    endtask

    function automatic logic [STW-1:0] thermo(input int n);
        return STW'((1 << n) - 1);
    endfunction

    initial begin
        m_valid = 1'b0; m_payload = '0; m_side = '0; m_bubble = 1'b0; m_run = 0;

        // Reset held two cycles with live inputs.
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b1; in_payload = '1; side_i = '1;
        cycle(); cycle();
        check("rst_valid", 128'(out_valid), 128'(0));

        // Release: all-ones payload goes through after one edge.
        rst = 1'b0;
        cycle();
        check("rel_payload", 128'(out_payload), 128'({PW{1'b1}}));

        // Bubble: this stage stopped, next stage running.
        stall = 6'b001111; side_i = 66'h1_2345;
        cycle();
        check("bub_side", 128'(side_o), 128'(66'h1_2345));
        check("bub_cnt",  128'(cnt8),   128'(1));

        // Hold: load 0xABC, then both stages stopped for three cycles.
        stall = '0; in_payload = PW'(12'hABC); in_valid = 1'b1;
        cycle();
        stall = 6'b011111;
        side_i = 66'hA; in_payload = PW'(1); cycle();
        side_i = 66'hB; in_payload = PW'(2); cycle();
        side_i = 66'hC; in_payload = PW'(3); cycle();
        check("hold_payload", 128'(out_payload), 128'(12'hABC));
        check("hold_side",    128'(side_o),      128'(66'hC));
        check("hold_cnt",     128'(cnt8),        128'(3));

        // Multi-cycle op in bubble, then advance clears sidecar and counter.
        stall = 6'b001111; side_i = 66'h3_0000_0000_0000_0011; cycle(); cycle();
        stall = '0; in_payload = PW'(64'h1234_5678_9ABC_DEF0); cycle();
        check("adv_side", 128'(side_o), 128'(0));
        check("adv_cnt",  128'(cnt8),   128'(0));

        // Flush beats hold with valid data.
        stall = 6'b011111; side_i = 66'h55; cycle();
        flush = 1'b1; cycle();
        check("flush_valid", 128'(out_valid), 128'(0));
        flush = 1'b0;

        // Saturation: stalled six cycles, 2-bit counter goes 1,2,3,3,3,3.
        stall = 6'b001111;
        for (int i = 0; i < 6; i++) cycle();
        check("sat_cnt2", 128'(cnt2), 128'(3));
        check("sat_cnt8", 128'(cnt8), 128'(6));

        // Gating: invalid slot advances with a zero payload.
        stall = '0; in_valid = 1'b0; in_payload = PW'(16'hFFFF); cycle();
        check("gate_payload", 128'(out_payload), 128'(0));

        // Random legal (thermometer) stall traffic with sparse rst/flush.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            stall      = thermo($urandom_range(0, 6));
            in_valid   = 1'(($urandom % 2));
            in_payload = PW'({$urandom, $urandom, $urandom, $urandom});
            side_i     = SW'({$urandom, $urandom, $urandom});
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // The stall vector must never stop the consumer while this stage runs.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(!stall[STG] && stall[STG+1]))
                else $error("illegal stall vector %b", stall);
        end
    end

endmodule
